cpu_seq: RTL

//  Multi-cycle control sequencer for the 8-bit register/ALU datapath. It owns
//  the program counter and instruction register, and runs FETCH/WAIT/DECODE/

---
 rtl/cpu_seq.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/cpu_seq.sv
// cpu_seq: multi-cycle control sequencer for the 8-bit register/ALU datapath.
// Owns the program counter and instruction register and steps each
// instruction through FETCH / WAIT / DECODE / EXEC / WB. It resolves JMP, JZ
// and HALT, and keeps a sticky record of illegal opcodes.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   start_i        begin/resume execution (level, sampled in IDLE/HALT)
//   stop_i         request a stop at the next instruction boundary
//   instr_i        ROM data {opcode[15:8], in1[7:4], in2[3:0]}
//   alu_out_i      ALU result for the current opcode/operands
//   rom_addr_o     ROM address (= pc)
//   rom_en_o       ROM read strobe, one cycle per fetch
//   opcode_o       IR opcode to the ALU
//   in1_idx_o      IR operand-1 select
//   in2_idx_o      IR operand-2 select
//   reg_we_o       register-file write enable (one-cycle pulse)
//   reg_waddr_o    register-file write index (= in1)
//   reg_wdata_o    register-file write data (registered ALU result)
//   busy_o         high in every state except IDLE/HALT
//   halted_o       high in HALT
//   illegal_o      sticky: an illegal opcode has been executed
module cpu_seq #(
    parameter int unsigned PC_W        = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned IDX_W       = 4,
    parameter int unsigned ROM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [15:0]       instr_i,
    input  logic [DATA_W-1:0] alu_out_i,
    output logic [PC_W-1:0]   rom_addr_o,
    output logic              rom_en_o,
    output logic [7:0]        opcode_o,
    output logic [IDX_W-1:0]  in1_idx_o,
    output logic [IDX_W-1:0]  in2_idx_o,
    output logic              reg_we_o,
    output logic [IDX_W-1:0]  reg_waddr_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    output logic              busy_o,
    output logic              halted_o,
    output logic              illegal_o
);

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned OP_W    = 8;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t              state_q;
    state_t              state_nxt;
    logic [PC_W-1:0]     pc_q;
    logic [INSTR_W-1:0]  ir_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                zero_q;
    logic                stop_q;

    logic                rom_en_nxt;
    logic                busy_nxt;
    logic                halted_nxt;
    logic                reg_we_nxt;

    // Opcode classes of the instruction held in IR
    logic [OP_W-1:0] op;
    logic            is_alu;
    logic            is_jmp;
    logic            is_jz;
    logic            is_halt;
    logic            is_illegal;
    logic            stop_pend;

    assign op         = ir_q[15:8];
    assign is_alu     = (op != '0) && !op[7];
    assign is_jmp     = (op == 8'h80);
    assign is_jz      = (op == 8'h81);
    assign is_halt    = (op == 8'hFF);
    assign is_illegal = op[7] && !(is_jmp || is_jz || is_halt);
    // A stop raised during WB itself still ends the run at this boundary
    assign stop_pend  = stop_q || stop_i;

    // IR/PC fields are flop outputs, so no path from instr_i/alu_out_i
    assign rom_addr_o  = pc_q;
    assign opcode_o    = ir_q[15:8];
    assign in1_idx_o   = IDX_W'(ir_q[7:4]);
    assign in2_idx_o   = IDX_W'(ir_q[3:0]);
    assign reg_waddr_o = IDX_W'(ir_q[7:4]);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:   if (start_i && !stop_i) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_WAIT;
            S_WAIT:   if (cnt_q == '0) state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC:   state_nxt = S_WB;
            S_WB: begin
                if (is_halt)        state_nxt = S_HALT;
                else if (stop_pend) state_nxt = S_IDLE;
                else                state_nxt = S_FETCH;
            end
            S_HALT:   if (start_i) state_nxt = S_FETCH;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output decode, computed from the next state so the flops line up with it
    always_comb begin
        rom_en_nxt = 1'b0;
        busy_nxt   = 1'b0;
        halted_nxt = 1'b0;
        reg_we_nxt = 1'b0;
        rom_en_nxt = (state_nxt == S_FETCH);
        busy_nxt   = (state_nxt != S_IDLE) && (state_nxt != S_HALT);
        halted_nxt = (state_nxt == S_HALT);
        reg_we_nxt = (state_nxt == S_WB) && is_alu;
    end

    // Datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= '0;
            ir_q        <= '0;
            cnt_q       <= '0;
            zero_q      <= 1'b0;
            stop_q      <= 1'b0;
            rom_en_o    <= 1'b0;
            busy_o      <= 1'b0;
            halted_o    <= 1'b0;
            reg_we_o    <= 1'b0;
            reg_wdata_o <= '0;
            illegal_o   <= 1'b0;
        end else begin
            rom_en_o <= rom_en_nxt;
            busy_o   <= busy_nxt;
            halted_o <= halted_nxt;
            reg_we_o <= reg_we_nxt;

            case (state_q)
                S_FETCH: cnt_q <= CNT_W'(ROM_LATENCY - 1);
                S_WAIT: begin
                    if (cnt_q == '0) ir_q  <= instr_i;
                    else             cnt_q <= cnt_q - CNT_W'(1);
                end
                S_EXEC: reg_wdata_o <= alu_out_i;
                S_WB: begin
                    if (is_alu)     zero_q    <= (reg_wdata_o == '0);
                    if (is_illegal) illegal_o <= 1'b1;
                    if (is_jmp || (is_jz && zero_q)) pc_q <= PC_W'(ir_q[7:0]);
                    else if (!is_halt)               pc_q <= pc_q + PC_W'(1);
                end
                S_HALT: begin
                    if (start_i) begin
                        pc_q   <= '0;
                        zero_q <= 1'b0;
                    end
                end
                default: ;
            endcase

            // Stop request latch: armed while running, dropped at a boundary
            if ((state_nxt == S_IDLE) || (state_nxt == S_HALT)) begin
                stop_q <= 1'b0;
            end else if (busy_o && stop_i) begin
                stop_q <= 1'b1;
            end
        end
    end

endmodule
